// File: rtl/dmem_mmio_if.sv
// Bus bundle between the MIPS MEM stage / TX consumer and the dmem_mmio block.
// The master side drives the store request and tx_ready; the slave side returns load data and the TX port.
interface dmem_mmio_if;
  logic        memwrite_m;
  logic [31:0] aluout_m;
  logic [31:0] writedata_m;
  logic [31:0] readdata_m;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output memwrite_m, aluout_m, writedata_m, tx_ready,
    input  readdata_m, tx_data, tx_valid
  );

  modport slave (
    input  memwrite_m, aluout_m, writedata_m, tx_ready,
    output readdata_m, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_mmio.sv
// MEM-stage data memory: word RAM plus memory-mapped LED, TX FIFO, status and cycle counter at 0xFFFF_00xx.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN enables the free-running 32-bit counter at offset 0x0C.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int LED_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  dmem_mmio_if.slave       bus,
  output logic [LED_W-1:0] led
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  localparam logic [5:0] OFF_LED  = 6'd0;
  localparam logic [5:0] OFF_TXD  = 6'd1;
  localparam logic [5:0] OFF_STAT = 6'd2;
  localparam logic [5:0] OFF_CYC  = 6'd3;

  logic [31:0] ram_q  [RAM_WORDS];
  logic [31:0] fifo_q [FIFO_DEPTH];

  logic [LED_W-1:0] led_q, led_d;
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;

  logic          io_sel;
  logic [5:0]    io_off;
  logic          sel_led, sel_txd, sel_stat, sel_cyc;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic [PW:0]   count;
  logic          full, empty, push, pop, push_ok;
  logic [4:0]    count5;
  logic [31:0]   cyc_val;
  logic          unused_addr_bits;

  always_comb begin
    io_sel   = (bus.aluout_m[31:16] == 16'hFFFF);
    io_off   = bus.aluout_m[7:2];
    sel_led  = io_sel && (io_off == OFF_LED);
    sel_txd  = io_sel && (io_off == OFF_TXD);
    sel_stat = io_sel && (io_off == OFF_STAT);
    sel_cyc  = io_sel && (io_off == OFF_CYC);
    ram_idx  = bus.aluout_m[AW+1:2];
    ram_we   = bus.memwrite_m && !io_sel && !reset;
  end

  assign unused_addr_bits = ^{bus.aluout_m[15:0], sel_cyc};

  // Full is judged on pre-edge state, so a push into a full FIFO drops even if a pop lands the same edge.
  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    count5  = 5'(count);
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    pop     = !empty && bus.tx_ready;
    push    = bus.memwrite_m && sel_txd;
    push_ok = push && !full && !reset;
  end

  always_comb begin
    led_d    = led_q;
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
    ovf_d    = ovf_q;
    if (bus.memwrite_m && sel_led)
      led_d = bus.writedata_m[LED_W-1:0];
    if (push && full)
      ovf_d = 1'b1;
    if (bus.memwrite_m && sel_stat)
      ovf_d = 1'b0;
    if (reset) begin
      led_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    led_q    <= led_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    ovf_q    <= ovf_d;
  end

  // Storage arrays carry no reset; writes are already gated off during reset cycles.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram_q[ram_idx] <= bus.writedata_m;
    if (push_ok)
      fifo_q[wr_ptr_q[PW-1:0]] <= bus.writedata_m;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (bus.memwrite_m && sel_cyc)
      cyc_d = '0;
    if (reset)
      cyc_d = '0;
  end

  always_ff @(posedge clk) begin
    cyc_q <= cyc_d;
  end

  assign cyc_val = cyc_q;
`else
  assign cyc_val = '0;
`endif

  always_comb begin
    bus.readdata_m = '0;
    if (!io_sel) begin
      bus.readdata_m = ram_q[ram_idx];
    end else begin
      case (io_off)
        OFF_LED:  bus.readdata_m = 32'(led_q);
        OFF_TXD:  bus.readdata_m = 32'(count);
        OFF_STAT: bus.readdata_m = {24'd0, count5, ovf_q, empty, full};
        OFF_CYC:  bus.readdata_m = cyc_val;
        default:  bus.readdata_m = '0;
      endcase
    end
  end

  assign bus.tx_data  = fifo_q[rd_ptr_q[PW-1:0]];
  assign bus.tx_valid = !empty;
  assign led          = led_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: the driver queues expected load/LED/valid values and TX words,
// and a negedge monitor pops and compares them whenever the DUT presents the matching output.
module tb_dmem_mmio;

  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_TXD  = 32'hFFFF_0004;
  localparam logic [31:0] A_STAT = 32'hFFFF_0008;
  localparam logic [31:0] A_CYC  = 32'hFFFF_000C;
  localparam int K_RD  = 0;
  localparam int K_LED = 1;
  localparam int K_VAL = 2;

`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] val;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] led;

  dmem_mmio_if bus ();

  dmem_mmio #(
    .RAM_WORDS (64),
    .FIFO_DEPTH(4),
    .LED_W     (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave),
    .led  (led)
  );

  exp_t        exp_q[$];
  logic [31:0] tx_q[$];
  int          check_req;
  int          checks;
  int          errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic rdy);
    bus.memwrite_m  = we;
    bus.aluout_m    = addr;
    bus.writedata_m = wd;
    bus.tx_ready    = rdy;
  endtask

  task automatic checkOutput(input int kind, input string name, input logic [31:0] val);
    exp_q.push_back('{kind, name, val});
    check_req++;
  endtask

  task automatic expectTx(input logic [31:0] v);
    tx_q.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_req = 0;
  endtask

  // Monitor: compares queued expectations and every accepted TX transfer.
  initial begin
    exp_t        e;
    logic [31:0] act;
    logic [31:0] want;
    forever begin
      @(negedge clk);
      for (int i = 0; i < check_req; i++) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_underflow: got no entry, required one queued check");
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            K_RD:    act = bus.readdata_m;
            K_LED:   act = 32'(led);
            default: act = {31'd0, bus.tx_valid};
          endcase
          if (act !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", e.name, act, e.val);
          end
        end
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL tx_unexpected: got 0x%08h, required no transfer", bus.tx_data);
        end else begin
          want = tx_q.pop_front();
          if (bus.tx_data !== want) begin
            errors++;
            $display("[TB] FAIL tx_data: got 0x%08h, required 0x%08h", bus.tx_data, want);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    check_req = 0;
    reset     = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    step();
    step();

    // Reset behaviour, including a store presented during reset.
    applyStimulus(1'b1, A_LED, 32'hFF, 1'b0);
    step();
    applyStimulus(1'b0, A_STAT, 32'd0, 1'b0);
    checkOutput(K_RD, "reset_stat", 32'h02);
    checkOutput(K_LED, "reset_led", 32'h0);
    checkOutput(K_VAL, "reset_valid", 32'h0);
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h20, 32'd0, 1'b0);

    // Cycle counter.
    repeat (10) step();
    applyStimulus(1'b0, A_CYC, 32'd0, 1'b0);
    checkOutput(K_RD, "cyc_after_10", CYC_EN ? 32'd10 : 32'd0);
    step();
    applyStimulus(1'b1, A_CYC, 32'h1234, 1'b0);
    checkOutput(K_RD, "cyc_at_clear", CYC_EN ? 32'd11 : 32'd0);
    step();
    applyStimulus(1'b0, A_CYC, 32'd0, 1'b0);
    checkOutput(K_RD, "cyc_cleared", 32'd0);
    step();
    checkOutput(K_RD, "cyc_next", CYC_EN ? 32'd1 : 32'd0);
    step();

    // RAM store/load, read-during-write, aliasing.
    applyStimulus(1'b1, 32'h10, 32'h1111_1111, 1'b0);
    step();
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    checkOutput(K_RD, "ram_rdw_old", 32'h1111_1111);
    step();
    applyStimulus(1'b0, 32'h10, 32'd0, 1'b0);
    checkOutput(K_RD, "ram_load", 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b0, 32'h110, 32'd0, 1'b0);
    checkOutput(K_RD, "ram_alias", 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b0, 32'hFFFE_0010, 32'd0, 1'b0);
    checkOutput(K_RD, "ram_near_io", 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b1, 32'h14, 32'h1234_5678, 1'b0);
    step();
    applyStimulus(1'b0, 32'h14, 32'd0, 1'b0);
    checkOutput(K_RD, "ram_load2", 32'h1234_5678);
    step();
    applyStimulus(1'b0, 32'h10, 32'd0, 1'b0);
    checkOutput(K_RD, "ram_neighbour", 32'hDEAD_BEEF);
    step();

    // LED register, unmapped I/O, reset clearing.
    applyStimulus(1'b1, A_LED, 32'h1A5, 1'b0);
    step();
    applyStimulus(1'b0, A_LED, 32'd0, 1'b0);
    checkOutput(K_RD, "led_read", 32'h0000_00A5);
    checkOutput(K_LED, "led_port", 32'hA5);
    step();
    applyStimulus(1'b0, 32'hFFFF_0010, 32'd0, 1'b0);
    checkOutput(K_RD, "io_unmapped_read", 32'd0);
    step();
    applyStimulus(1'b1, 32'hFFFF_0010, 32'hFFFF_FFFF, 1'b0);
    step();
    applyStimulus(1'b0, A_LED, 32'd0, 1'b0);
    checkOutput(K_LED, "led_after_unmapped", 32'hA5);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput(K_LED, "led_after_reset", 32'h0);
    checkOutput(K_RD, "led_read_after_reset", 32'h0);
    step();

    // FIFO fill, overflow, drain.
    for (int v = 1; v <= 4; v++) begin
      applyStimulus(1'b1, A_TXD, 32'(v), 1'b0);
      expectTx(32'(v));
      if (v == 2) checkOutput(K_VAL, "valid_after_push", 32'h1);
      step();
    end
    applyStimulus(1'b0, A_STAT, 32'd0, 1'b0);
    checkOutput(K_RD, "stat_full", 32'h21);
    step();
    applyStimulus(1'b0, A_TXD, 32'd0, 1'b0);
    checkOutput(K_RD, "txd_count", 32'd4);
    step();
    applyStimulus(1'b1, A_TXD, 32'd5, 1'b0);
    step();
    applyStimulus(1'b0, A_STAT, 32'd0, 1'b0);
    checkOutput(K_RD, "stat_ovf", 32'h25);
    step();
    repeat (4) begin
      applyStimulus(1'b0, 32'h20, 32'd0, 1'b1);
      step();
    end
    applyStimulus(1'b0, A_STAT, 32'd0, 1'b1);
    checkOutput(K_RD, "stat_drained", 32'h06);
    checkOutput(K_VAL, "valid_drained", 32'h0);
    step();
    applyStimulus(1'b1, A_STAT, 32'hABCD, 1'b0);
    step();
    applyStimulus(1'b0, A_STAT, 32'd0, 1'b0);
    checkOutput(K_RD, "stat_ovf_cleared", 32'h02);
    step();

    // Push into full FIFO while popping: push dropped, pop completes.
    for (int v = 11; v <= 14; v++) begin
      applyStimulus(1'b1, A_TXD, 32'(v), 1'b0);
      expectTx(32'(v));
      step();
    end
    applyStimulus(1'b1, A_TXD, 32'd9, 1'b1);
    step();
    applyStimulus(1'b0, A_STAT, 32'd0, 1'b0);
    checkOutput(K_RD, "stat_full_pushpop", 32'h1C);
    step();
    applyStimulus(1'b1, A_STAT, 32'd0, 1'b0);
    step();
    applyStimulus(1'b0, A_STAT, 32'd0, 1'b0);
    checkOutput(K_RD, "stat_ovf_clear2", 32'h18);
    step();
    repeat (3) begin
      applyStimulus(1'b0, 32'h20, 32'd0, 1'b1);
      step();
    end
    applyStimulus(1'b0, A_STAT, 32'd0, 1'b0);
    checkOutput(K_RD, "stat_empty2", 32'h02);
    checkOutput(K_VAL, "valid_empty2", 32'h0);
    step();

    // Streaming push/pop across pointer wrap.
    repeat (2) begin
      for (int v = 1; v <= 7; v++) begin
        applyStimulus(1'b1, A_TXD, 32'(v), 1'b1);
        expectTx(32'(v));
        step();
      end
      applyStimulus(1'b0, 32'h20, 32'd0, 1'b1);
      step();
    end
    applyStimulus(1'b0, A_STAT, 32'd0, 1'b0);
    checkOutput(K_RD, "stat_after_stream", 32'h02);
    step();
    applyStimulus(1'b0, 32'h20, 32'd0, 1'b0);
    step();

    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL tx_leftover: got %0d undelivered words, required 0", tx_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL exp_leftover: got %0d unchecked entries, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
